// File: rtl/bcd_to_bin_pkg.sv
// Shared definitions for the BCD conversion blocks.
//   DIGIT_W     : width of one packed BCD digit
//   BCD_MAX     : largest legal digit value
//   state_e     : converter FSM encoding (idle / converting / reporting)
//   digit_corr  : per-digit correction step of reverse double-dabble
package bcd_to_bin_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StConv = 2'd1,
    StDone = 2'd2
  } state_e;

  // After a right shift, a digit that received the LSB of its upper neighbour
  // carries an extra 8 that stands for decimal 5; subtracting 3 restores it.
  function automatic logic [DIGIT_W-1:0] digit_corr(input logic [DIGIT_W-1:0] d);
    return (d >= 4'd8) ? d - 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// Request/result bundle of the BCD-to-binary converter.
//   i_start : one-cycle conversion request (sampled only when idle)
//   i_bcd   : packed BCD input, digit 0 in i_bcd[3:0]
//   o_bin   : binary result, held until the next accepted request
//   o_busy  : conversion in progress
//   o_done  : one-cycle completion pulse
//   o_err   : with o_done, input contained a digit above 9
// master drives the request side, slave is the converter.
interface bcd_to_bin_if
  import bcd_to_bin_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BW     = 10
);

  logic                        i_start;
  logic [DIGIT_W*DIGITS-1:0]   i_bcd;
  logic [BW-1:0]               o_bin;
  logic                        o_busy;
  logic                        o_done;
  logic                        o_err;

  modport master (
    output i_start,
    output i_bcd,
    input  o_bin,
    input  o_busy,
    input  o_done,
    input  o_err
  );

  modport slave (
    input  i_start,
    input  i_bcd,
    output o_bin,
    output o_busy,
    output o_done,
    output o_err
  );

endinterface

// File: rtl/bcd_digit_corr.sv
// Combinational correction for one BCD digit: d >= 8 ? d - 3 : d.
//   i_digit : digit after the right shift
//   o_digit : corrected digit
module bcd_digit_corr
  import bcd_to_bin_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  assign o_digit = digit_corr(i_digit);

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble).
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_to_bin_if (request, result, busy/done/err)
// A valid request takes BW shift-and-correct iterations; Done follows BW+1
// cycles after the accepted Start. A request with an illegal digit skips the
// iterations and reports Done+Err on the next cycle with Bin = 0.
// BW must satisfy 2**BW >= 10**DIGITS.
module bcd_to_bin
  import bcd_to_bin_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BW     = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  bcd_to_bin_if.slave    bus
);

  localparam int unsigned BcdW = DIGIT_W * DIGITS;
  localparam int unsigned SrW  = BcdW + BW;
  localparam int unsigned CntW = $clog2(BW + 1);

  state_e            r_state;
  logic [SrW-1:0]    r_sr;
  logic [CntW-1:0]   r_cnt;
  logic [BW-1:0]     r_bin;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [SrW-1:0]    w_sr_shift;
  logic [BcdW-1:0]   w_bcd_corr;
  logic [SrW-1:0]    w_sr_next;
  logic              w_bad;

  // Shift the combined {bcd, bin} register, then correct each BCD digit.
  assign w_sr_shift = r_sr >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .i_digit (w_sr_shift[BW + g*DIGIT_W +: DIGIT_W]),
      .o_digit (w_bcd_corr[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign w_sr_next = {w_bcd_corr, w_sr_shift[BW-1:0]};

  always_comb begin
    w_bad = 1'b0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (bus.i_bcd[d*DIGIT_W +: DIGIT_W] > BCD_MAX) begin
        w_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.i_start) begin
            if (w_bad) begin
              r_bin   <= '0;
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_sr    <= {bus.i_bcd, {BW{1'b0}}};
              r_cnt   <= CntW'(BW);
              r_busy  <= 1'b1;
              r_state <= StConv;
            end
          end
        end
        StConv: begin
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt - CntW'(1);
          // Last iteration: the bin field of the next value is the result.
          if (r_cnt == CntW'(1)) begin
            r_bin   <= w_sr_next[BW-1:0];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_err   <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.o_bin  = r_bin;
  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
  assign bus.o_err  = r_err;

endmodule

// File: tb/tb_bcd_to_bin.sv
module tb_bcd_to_bin;

  localparam int DIGITS = 3;
  localparam int BW     = 10;

  logic clk;
  logic rst_n;

  bcd_to_bin_if #(.DIGITS(DIGITS), .BW(BW)) bus ();

  bcd_to_bin #(.DIGITS(DIGITS), .BW(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] b;
    b[11:8] = 4'(v / 100);
    b[7:4]  = 4'((v / 10) % 10);
    b[3:0]  = 4'(v % 10);
    return b;
  endfunction

  typedef struct {
    logic [11:0] bcd;
    int          bin;
    int          err;
    int          lat;
    int          busy_n;
  } vec_t;

  // One isolated request; observes 16 cycles after the Start edge.
  task automatic run_conv(input logic [11:0] bcd, output int bin, output int err,
                          output int lat, output int busy_n, output int done_n);
    bin = -1; err = -1; lat = 0; busy_n = 0; done_n = 0;
    @(negedge clk);
    bus.i_bcd   = bcd;
    bus.i_start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) bus.i_start = 1'b0;
      if (bus.o_busy) busy_n++;
      if (bus.o_done) begin
        done_n++;
        if (lat == 0) begin
          lat = c;
          bin = int'(bus.o_bin);
          err = int'(bus.o_err);
        end
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    int bin, err, lat, busy_n, done_n;

    vecs[0] = '{12'h000,   0, 0, 11, 10};
    vecs[1] = '{12'h999, 999, 0, 11, 10};
    vecs[2] = '{12'h255, 255, 0, 11, 10};
    vecs[3] = '{12'h1A3,   0, 1,  1,  0};
    vecs[4] = '{12'h010,  10, 0, 11, 10};
    vecs[5] = '{12'h800, 800, 0, 11, 10};
    vecs[6] = '{12'h09A,   0, 1,  1,  0};
    vecs[7] = '{12'h001,   1, 0, 11, 10};

    rst_n       = 1'b0;
    bus.i_start = 1'b0;
    bus.i_bcd   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_bin",  int'(bus.o_bin),  0);
    check("reset_busy", int'(bus.o_busy), 0);
    check("reset_done", int'(bus.o_done), 0);
    check("reset_err",  int'(bus.o_err),  0);

    foreach (vecs[i]) begin
      run_conv(vecs[i].bcd, bin, err, lat, busy_n, done_n);
      check($sformatf("vec%0d_bin", i),    bin,    vecs[i].bin);
      check($sformatf("vec%0d_err", i),    err,    vecs[i].err);
      check($sformatf("vec%0d_lat", i),    lat,    vecs[i].lat);
      check($sformatf("vec%0d_busy", i),   busy_n, vecs[i].busy_n);
      check($sformatf("vec%0d_done_n", i), done_n, 1);
    end

    // Start re-pulsed in the 4th cycle of a conversion must be ignored.
    begin
      int dn = 0;
      int b = -1;
      @(negedge clk);
      bus.i_bcd   = 12'h123;
      bus.i_start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        bus.i_start = (c == 3);
        if (c == 4) bus.i_bcd = 12'h777;
        if (bus.o_done) begin
          dn++;
          b = int'(bus.o_bin);
        end
      end
      check("ignore_done_n", dn, 1);
      check("ignore_bin",    b,  123);
      check("ignore_busy",   int'(bus.o_busy), 0);
    end

    // Async reset in the 5th CONV cycle aborts without a Done.
    begin
      int dn = 0;
      @(negedge clk);
      bus.i_bcd   = 12'h456;
      bus.i_start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        bus.i_start = 1'b0;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_bin",  int'(bus.o_bin),  0);
      check("abort_busy", int'(bus.o_busy), 0);
      check("abort_done", int'(bus.o_done), 0);
      check("abort_err",  int'(bus.o_err),  0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (bus.o_done || bus.o_busy) dn++;
      end
      check("abort_no_done", dn, 0);
      run_conv(12'h789, bin, err, lat, busy_n, done_n);
      check("after_abort_bin", bin, 789);
      check("after_abort_lat", lat, 11);
    end

    // Exhaustive back-to-back sweep with Start held high.
    begin
      int v = 0;
      int cyc = 0;
      int prev = -1;
      @(negedge clk);
      bus.i_bcd   = to_bcd(0);
      bus.i_start = 1'b1;
      while (v < 1000 && cyc < 13000) begin
        @(negedge clk);
        cyc++;
        if (bus.o_done) begin
          check($sformatf("sweep_bin_%0d", v), int'(bus.o_bin), v);
          check($sformatf("sweep_err_%0d", v), int'(bus.o_err), 0);
          if (prev >= 0) check($sformatf("sweep_gap_%0d", v), cyc - prev, BW + 2);
          prev = cyc;
          v++;
          if (v < 1000) bus.i_bcd = to_bcd(v);
          else bus.i_start = 1'b0;
        end
      end
      bus.i_start = 1'b0;
      check("sweep_count", v, 1000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
